// File: rtl/alu_unit.sv
// alu_unit: 8-bit registered ALU for the byte-code datapath.
// Single-cycle ops write result on the launch edge. MUL, DIV and MOD are
// iterative, take MD_CYCLES edges and hold busy high while running.
// Optional feature macro: ALU_MULDIV_EN. Defining it builds the MUL/DIV/MOD engine.
// Leaving it undefined makes ops 11-13 reserved and ties busy low.
module alu_unit #(
  parameter int WIDTH     = 8,
  parameter int MD_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam logic [5:0] OP_NOP = 6'd0;
  localparam logic [5:0] OP_ADD = 6'd1;
  localparam logic [5:0] OP_SUB = 6'd2;
  localparam logic [5:0] OP_AND = 6'd3;
  localparam logic [5:0] OP_OR  = 6'd4;
  localparam logic [5:0] OP_XOR = 6'd5;
  localparam logic [5:0] OP_NOT = 6'd6;
  localparam logic [5:0] OP_SHL = 6'd7;
  localparam logic [5:0] OP_SHR = 6'd8;
  localparam logic [5:0] OP_INC = 6'd9;
  localparam logic [5:0] OP_DEC = 6'd10;
  localparam logic [5:0] OP_MUL = 6'd11;
  localparam logic [5:0] OP_DIV = 6'd12;
  localparam logic [5:0] OP_MOD = 6'd13;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Last launched {op,a,b}; vld_p0 clear means nothing launched since reset.
  logic [5:0]       op_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             vld_p0;

  logic             launch;
  logic             is_md;
  logic             md_done;
  logic [WIDTH-1:0] md_res;

  // Single-cycle operation table; ops 11-13 also land on the default
  // (reserved -> 0) when the iterative engine is not built.
  function automatic logic [WIDTH-1:0] alu_eval(input logic [5:0]       f,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    case (f)
      OP_ADD:  alu_eval = x + y;
      OP_SUB:  alu_eval = x - y;
      OP_AND:  alu_eval = x & y;
      OP_OR:   alu_eval = x | y;
      OP_XOR:  alu_eval = x ^ y;
      OP_NOT:  alu_eval = ~x;
      OP_SHL:  alu_eval = x << y[2:0];
      OP_SHR:  alu_eval = x >> y[2:0];
      OP_INC:  alu_eval = x + ONE;
      OP_DEC:  alu_eval = x - ONE;
      default: alu_eval = '0;
    endcase
  endfunction

  // Launch only while idle, and only for a new triple (or first edge after reset).
  assign launch = !busy && (!vld_p0 || ({op, a, b} != {op_p0, a_p0, b_p0}));

`ifdef ALU_MULDIV_EN
  localparam int CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);

  // ---- stage p1: iterative multiply / restoring divide ----
  logic             busy_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             mul_p1;
  logic             mod_p1;
  logic [WIDTH-1:0] mcand_p1;
  logic [WIDTH-1:0] mplier_p1;
  logic [WIDTH-1:0] acc_p1;
  logic [WIDTH-1:0] rem_p1;
  logic [WIDTH-1:0] quo_p1;
  logic [WIDTH-1:0] dvsr_p1;

  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  assign is_md   = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  assign busy    = busy_p1;
  assign md_done = busy_p1 && (cnt_p1 == CNT_LAST);
  assign md_res  = mul_p1 ? acc_nx : (mod_p1 ? rem_nx : quo_nx);

  // One shift-add bit and one restoring-division bit per cycle. A zero
  // divisor always "subtracts", naturally giving quotient all-ones and
  // remainder equal to the dividend.
  always_comb begin
    acc_nx = acc_p1 + (mplier_p1[0] ? mcand_p1 : '0);
    rem_sh = {rem_p1, quo_p1[WIDTH-1]};
    rem_nx = rem_sh[WIDTH-1:0];
    quo_nx = {quo_p1[WIDTH-2:0], 1'b0};
    if (rem_sh >= {1'b0, dvsr_p1}) begin
      rem_nx = WIDTH'(rem_sh - {1'b0, dvsr_p1});
      quo_nx = {quo_p1[WIDTH-2:0], 1'b1};
    end
  end

  // Iteration control: busy and cycle counter, abandoned on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_p1 <= 1'b0;
      cnt_p1  <= '0;
    end else if (md_done) begin
      busy_p1 <= 1'b0;
      cnt_p1  <= '0;
    end else if (busy_p1) begin
      cnt_p1  <= cnt_p1 + 1'b1;
    end else if (launch && is_md) begin
      busy_p1 <= 1'b1;
      cnt_p1  <= '0;
    end
  end

  // Iteration datapath: operands latched at launch, then stepped each cycle.
  always_ff @(posedge clk) begin
    if (busy_p1) begin
      acc_p1    <= acc_nx;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
      rem_p1    <= rem_nx;
      quo_p1    <= quo_nx;
    end else if (launch && is_md) begin
      mul_p1    <= (op == OP_MUL);
      mod_p1    <= (op == OP_MOD);
      acc_p1    <= '0;
      mcand_p1  <= a;
      mplier_p1 <= b;
      rem_p1    <= '0;
      quo_p1    <= a;
      dvsr_p1   <= b;
    end
  end
`else
  assign is_md   = 1'b0;
  assign busy    = 1'b0;
  assign md_done = 1'b0;
  assign md_res  = '0;
`endif

  // ---- stage p0: launch tracking ----
  // Record the launched triple so identical inputs never relaunch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_p0  <= '1;
      a_p0   <= '1;
      b_p0   <= '1;
      vld_p0 <= 1'b0;
    end else if (launch) begin
      op_p0  <= op;
      a_p0   <= a;
      b_p0   <= b;
      vld_p0 <= 1'b1;
    end
  end

  // Result register: single-cycle ops on launch (NOP holds), iterative ops on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else if (md_done) begin
      result <= md_res;
    end else if (launch && !is_md && (op != OP_NOP)) begin
      result <= alu_eval(op, a, b);
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and randomized checks of alu_unit against an
// arithmetic reference model. Follows ALU_MULDIV_EN the same way as the design.
module tb_alu_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [5:0] op;
  logic [7:0] result;
  logic       busy;

`ifdef ALU_MULDIV_EN
  localparam bit MD_ON = 1'b1;
`else
  localparam bit MD_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_unit #(.WIDTH(8), .MD_CYCLES(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .op     (op),
    .result (result),
    .busy   (busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]  exp_res;
  logic        exp_busy;
  int          md_left;
  logic [7:0]  md_val;
  logic        m_vld;
  logic [21:0] m_last;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [5:0] f, input logic [7:0] x,
                                        input logic [7:0] y);
    logic [15:0] p;
    p = {8'd0, x} * {8'd0, y};
    case (f)
      6'd1:    return x + y;
      6'd2:    return x - y;
      6'd3:    return x & y;
      6'd4:    return x | y;
      6'd5:    return x ^ y;
      6'd6:    return ~x;
      6'd7:    return x << y[2:0];
      6'd8:    return x >> y[2:0];
      6'd9:    return x + 8'd1;
      6'd10:   return x - 8'd1;
      6'd11:   return MD_ON ? p[7:0] : 8'h00;
      6'd12:   return MD_ON ? ((y == 8'd0) ? 8'hFF : x / y) : 8'h00;
      6'd13:   return MD_ON ? ((y == 8'd0) ? x : x % y) : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit is_md(input logic [5:0] f);
    return MD_ON && (f >= 6'd11) && (f <= 6'd13);
  endfunction

  task automatic model_reset();
    exp_res  = 8'h00;
    exp_busy = 1'b0;
    md_left  = 0;
    m_vld    = 1'b0;
    m_last   = '1;
  endtask

  // What one rising edge does, given the inputs present before it.
  task automatic model_edge(input logic [5:0] f, input logic [7:0] x, input logic [7:0] y);
    if (md_left > 0) begin
      md_left--;
      if (md_left == 0) begin
        exp_res  = md_val;
        exp_busy = 1'b0;
      end
    end else if (!m_vld || ({f, x, y} != m_last)) begin
      m_vld  = 1'b1;
      m_last = {f, x, y};
      if (is_md(f)) begin
        md_val   = ref_op(f, x, y);
        md_left  = 8;
        exp_busy = 1'b1;
      end else if (f != 6'd0) begin
        exp_res = ref_op(f, x, y);
      end
    end
  endtask

  task automatic apply(input logic [5:0] f, input logic [7:0] x, input logic [7:0] y);
    op = f;
    a  = x;
    b  = y;
  endtask

  task automatic step(input string tag);
    logic [5:0] f;
    logic [7:0] x;
    logic [7:0] y;
    f = op;
    x = a;
    y = b;
    @(posedge clk);
    #1;
    model_edge(f, x, y);
    chk({tag, ".res"}, result, exp_res);
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, exp_busy});
  endtask

  // Called 1 time unit after an edge: assert reset mid-cycle, check, release.
  task automatic pulse_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_res"}, result, 8'h00);
    chk({tag, ".rst_busy"}, {7'd0, busy}, 8'h00);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic run_md(input string tag, input logic [5:0] f, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] want);
    apply(f, x, y);
    step({tag, ".launch"});
    chk({tag, ".busy_rise"}, {7'd0, busy}, {7'd0, MD_ON});
    for (int i = 0; i < 8; i++) step(tag);
    chk({tag, ".final"}, result, MD_ON ? want : 8'h00);
  endtask

  logic [5:0] t_op [6] = '{6'd1, 6'd2, 6'd5, 6'd7, 6'd6, 6'd20};
  logic [7:0] t_a  [6] = '{8'hFF, 8'h03, 8'hF0, 8'h81, 8'h0F, 8'h37};
  logic [7:0] t_b  [6] = '{8'h02, 8'h05, 8'hAA, 8'h09, 8'h00, 8'h44};
  logic [7:0] t_r  [6] = '{8'h01, 8'hFE, 8'h5A, 8'h02, 8'hF0, 8'h00};

  initial begin
    rst_n = 1'b0;
    apply(6'd1, 8'h05, 8'h03);
    model_reset();
    #17;
    chk("reset.res", result, 8'h00);
    chk("reset.busy", {7'd0, busy}, 8'h00);
    #2;
    rst_n = 1'b1;
    step("release");
    chk("release.add", result, 8'h08);

    for (int i = 0; i < 6; i++) begin
      apply(t_op[i], t_a[i], t_b[i]);
      step("tbl");
      chk($sformatf("tbl%0d.const", i), result, t_r[i]);
    end

    // Reset mid-cycle with a non-zero result, then relaunch of unchanged inputs.
    apply(6'd1, 8'hFF, 8'h02);
    step("pre_rst");
    pulse_reset("midrst");
    step("relaunch");
    chk("relaunch.const", result, 8'h01);
    for (int i = 0; i < 3; i++) step("hold_sc");

    run_md("mul", 6'd11, 8'h0C, 8'h0B, 8'h84);

    // MUL with inputs churning while busy; model decides what counts.
    apply(6'd11, 8'h13, 8'h07);
    step("mulchg.launch");
    for (int i = 0; i < 8; i++) begin
      apply(6'($urandom_range(0, 63)), 8'($urandom), 8'($urandom));
      step("mulchg");
    end
    apply(6'd1, 8'h10, 8'h20);
    step("after_md");
    for (int i = 0; i < 4; i++) step("hold_md");

    run_md("div",  6'd12, 8'hC8, 8'h07, 8'h1C);
    run_md("mod",  6'd13, 8'hC8, 8'h07, 8'h04);
    run_md("div0", 6'd12, 8'hC8, 8'h00, 8'hFF);
    run_md("mod0", 6'd13, 8'h2A, 8'h00, 8'h2A);
    for (int i = 0; i < 3; i++) step("hold_div");

    // Reset on cycle 4 of a DIV, then it relaunches from the same inputs.
    apply(6'd12, 8'h64, 8'h09);
    step("divrst.launch");
    for (int i = 0; i < 3; i++) step("divrst.run");
    pulse_reset("divrst");
    run_md("divrst.again", 6'd12, 8'h64, 8'h09, 8'h0B);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(14, 63));
        else op = 6'($urandom_range(0, 13));
        a = 8'($urandom);
        b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      end
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
